// File: rtl/seqdet_sched_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_sched_pkg
// Shared definitions for the sequence-detector scheduler:
//   - sched_state_e : scheduler FSM states
//   - DET_PATTERN / DET_LEN : the 110101 pattern the shared detector looks for,
//     kept here so reference models use the same constant
//   - TOTAL_W : width of each per-requester hit accumulator (used when
//     SEQDET_TOTALS_EN is defined)
//   - sat_add_total : saturating add for the accumulators
// -----------------------------------------------------------------------------
package seqdet_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } sched_state_e;

    localparam logic [5:0] DET_PATTERN = 6'b110101;
    localparam int         DET_LEN     = 6;
    localparam int         TOTAL_W     = 16;

    // Add inc to acc, clamping at all-ones instead of wrapping.
    function automatic logic [TOTAL_W-1:0] sat_add_total(
        input logic [TOTAL_W-1:0] acc,
        input logic [TOTAL_W-1:0] inc
    );
        logic [TOTAL_W:0] sum_s;
        sum_s = {1'b0, acc} + {1'b0, inc};
        if (sum_s[TOTAL_W]) begin
            return {TOTAL_W{1'b1}};
        end else begin
            return sum_s[TOTAL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/seqdet_rr_arbiter.sv
// -----------------------------------------------------------------------------
// seqdet_rr_arbiter
// Combinational round-robin arbiter: grants the first set req_valid bit at or
// after rr_ptr, wrapping modulo NREQ.
// Ports:
//   req_valid [NREQ]  in  : request bits
//   rr_ptr    [ID_W]  in  : highest-priority index this cycle
//   grant     [NREQ]  out : one-hot grant (all zero when nothing is valid)
//   grant_idx [ID_W]  out : index of the granted requester
//   any_valid         out : at least one request is pending
// -----------------------------------------------------------------------------
module seqdet_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_valid
);

    assign any_valid = |req_valid;

    // Scan requesters starting at rr_ptr and pick the first valid one.
    always_comb begin : arb_scan
        int   cand_s;
        logic found_s;
        found_s   = 1'b0;
        cand_s    = 0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = (int'(rr_ptr) + k) % NREQ;
            if (!found_s && req_valid[ID_W'(cand_s)]) begin
                found_s   = 1'b1;
                grant_idx = ID_W'(cand_s);
            end else begin
                found_s   = found_s;
            end
        end
        grant = {{(NREQ-1){1'b0}}, found_s} << grant_idx;
    end

endmodule

// File: rtl/seqdet_scheduler.sv
// -----------------------------------------------------------------------------
// seqdet_scheduler
// Shares one bit-serial 110101 detector between NREQ word-wide requesters.
// Each accepted word is preceded by a one-cycle detector clear, shifted in
// MSB-first, and the detector hits within the word are counted and reported
// with the requester id.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid [NREQ]    : per-requester word valid
//   req_data  [NREQ*W]  : requester i's word at [i*WORD_W +: WORD_W]
//   req_ready [NREQ]    : one-hot accept pulse to the granted requester
//   det_rst             : reset to the detector (also asserted while rst_n=0)
//   det_ip / det_op     : serial bit to / match flag from the detector
//   res_valid/res_ready : result handshake
//   res_id, res_hits    : requester id and hit count of the reported word
// Optional (macro SEQDET_TOTALS_EN):
//   totals_clr          : synchronous clear of all accumulators
//   total_hits [NREQ*16]: per-requester saturating hit accumulators
// -----------------------------------------------------------------------------
module seqdet_scheduler
    import seqdet_sched_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int WORD_W = 8,
    localparam int HIT_W  = $clog2(WORD_W + 1),
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef SEQDET_TOTALS_EN
    input  logic                   totals_clr,
    output logic [NREQ*TOTAL_W-1:0] total_hits,
`endif
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WORD_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   det_rst,
    output logic                   det_ip,
    input  logic                   det_op,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [HIT_W-1:0]       res_hits,
    input  logic                   res_ready
);

    localparam int IDX_W = $clog2(WORD_W);

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [WORD_W-1:0] shift_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [HIT_W-1:0]  hits_r;
    logic [ID_W-1:0]   res_id_r;
    logic [NREQ-1:0]   grant_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic              any_valid_s;
    logic              last_bit_s;
    logic              handshake_s;

    seqdet_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_valid (any_valid_s)
    );

    assign last_bit_s  = (bit_idx_r == IDX_W'(WORD_W - 1));
    assign handshake_s = (state_r == REPORT) && res_ready;

    // rst_n is folded into req_ready and det_rst so both hold their reset
    // values while reset is asserted, independent of the request inputs.
    assign req_ready = grant_s & {NREQ{(state_r == IDLE) && rst_n}};
    assign det_rst   = !rst_n || (state_r == CLEAR);
    assign det_ip    = (state_r == SHIFT) && shift_r[WORD_W-1];
    assign res_valid = (state_r == REPORT);
    assign res_id    = res_id_r;
    assign res_hits  = hits_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = CLEAR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR:  state_nxt_s = SHIFT;
            SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DRAIN:  state_nxt_s = REPORT;
            REPORT: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Word capture, serial shift and hit counting. det_op lags det_ip by one
    // cycle, so the first SHIFT cycle's det_op is skipped and DRAIN picks up
    // the result of the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r  <= '0;
            shift_r   <= '0;
            bit_idx_r <= '0;
            hits_r    <= '0;
            res_id_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        shift_r  <= req_data[int'(grant_idx_s)*WORD_W +: WORD_W];
                        res_id_r <= grant_idx_s;
                        hits_r   <= '0;
                        if (grant_idx_s == ID_W'(NREQ - 1)) begin
                            rr_ptr_r <= '0;
                        end else begin
                            rr_ptr_r <= grant_idx_s + ID_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    bit_idx_r <= '0;
                end
                SHIFT: begin
                    shift_r   <= shift_r << 1;
                    bit_idx_r <= bit_idx_r + IDX_W'(1);
                    if (bit_idx_r != '0) begin
                        hits_r <= hits_r + HIT_W'(det_op);
                    end
                end
                DRAIN: begin
                    hits_r <= hits_r + HIT_W'(det_op);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQDET_TOTALS_EN
    logic [TOTAL_W-1:0] totals_r [NREQ];

    // Per-requester saturating accumulators; a clear beats a same-cycle add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                totals_r[i] <= '0;
            end
        end else if (totals_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                totals_r[i] <= '0;
            end
        end else if (handshake_s) begin
            totals_r[res_id_r] <= sat_add_total(totals_r[res_id_r], TOTAL_W'(hits_r));
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_totals
        assign total_hits[g*TOTAL_W +: TOTAL_W] = totals_r[g];
    end
`else
    logic unused_handshake_s;
    assign unused_handshake_s = handshake_s;
`endif

endmodule

// File: tb/tb_seqdet_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seqdet_scheduler
// Scoreboard bench: stimulus pushes expected grants/results into queues and
// monitors pop and compare whenever the DUT grants or hands over a result.
// A behavioural 110101 detector (one cycle latency, overlapping matches)
// sits on each DUT's det_* pins. A second instance runs 16-bit words.
// -----------------------------------------------------------------------------
module tb_seqdet_scheduler;
    import seqdet_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int N2   = 2;
    localparam int W2   = 16;

    typedef struct {
        int id;
        int hits;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*W-1:0]   req_data  = '0;
    logic [NREQ-1:0]     req_ready;
    logic                det_rst, det_ip;
    logic                det_op = 1'b0;
    logic                res_valid;
    logic [1:0]          res_id;
    logic [3:0]          res_hits;
    logic                res_ready = 1'b1;

    logic [N2-1:0]       req_valid2 = '0;
    logic [N2*W2-1:0]    req_data2  = '0;
    logic [N2-1:0]       req_ready2;
    logic                det_rst2, det_ip2;
    logic                det_op2 = 1'b0;
    logic                res_valid2;
    logic [0:0]          res_id2;
    logic [4:0]          res_hits2;
    logic                res_ready2 = 1'b1;

`ifdef SEQDET_TOTALS_EN
    logic                    totals_clr = 1'b0;
    logic [NREQ*TOTAL_W-1:0] total_hits;
    logic [N2*TOTAL_W-1:0]   total_hits2;
`endif

    seqdet_scheduler #(.NREQ(NREQ), .WORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQDET_TOTALS_EN
        .totals_clr(totals_clr), .total_hits(total_hits),
`endif
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .det_rst(det_rst), .det_ip(det_ip), .det_op(det_op),
        .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits),
        .res_ready(res_ready)
    );

    seqdet_scheduler #(.NREQ(N2), .WORD_W(W2)) dut2 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQDET_TOTALS_EN
        .totals_clr(totals_clr), .total_hits(total_hits2),
`endif
        .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
        .det_rst(det_rst2), .det_ip(det_ip2), .det_op(det_op2),
        .res_valid(res_valid2), .res_id(res_id2), .res_hits(res_hits2),
        .res_ready(res_ready2)
    );

    // Reference detectors: op goes high the cycle after the last pattern bit.
    logic [5:0] hist1 = 6'd0;
    logic [5:0] hist2 = 6'd0;
    always @(posedge clk) begin
        if (det_rst) begin
            hist1  <= 6'd0;
            det_op <= 1'b0;
        end else begin
            hist1  <= {hist1[4:0], det_ip};
            det_op <= ({hist1[4:0], det_ip} == DET_PATTERN);
        end
        if (det_rst2) begin
            hist2   <= 6'd0;
            det_op2 <= 1'b0;
        end else begin
            hist2   <= {hist2[4:0], det_ip2};
            det_op2 <= ({hist2[4:0], det_ip2} == DET_PATTERN);
        end
    end

    int   errors = 0;
    int   checks = 0;
    int   res_seen = 0;
    res_t exp_q[$];
    res_t exp2_q[$];
    int   grant_q[$];
    int   grant2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event required one", name);
    endtask

    // Monitors: compare grants and delivered results against the queues.
    always @(negedge clk) begin
        res_t e;
        int   g;
        if (rst_n) begin
            if (res_valid && res_ready) begin
                res_seen++;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("res_id", 32'(res_id), 32'(e.id));
                    check("res_hits", 32'(res_hits), 32'(e.hits));
                end
            end
            if (req_ready != '0) begin
                if (grant_q.size() == 0) begin
                    timeout_fail("unexpected_grant");
                end else begin
                    g = grant_q.pop_front();
                    check("grant", 32'(req_ready), 32'd1 << g);
                end
            end
            if (res_valid2 && res_ready2) begin
                if (exp2_q.size() == 0) begin
                    timeout_fail("unexpected_result2");
                end else begin
                    e = exp2_q.pop_front();
                    check("res_id2", 32'(res_id2), 32'(e.id));
                    check("res_hits2", 32'(res_hits2), 32'(e.hits));
                end
            end
            if (req_ready2 != '0) begin
                if (grant2_q.size() == 0) begin
                    timeout_fail("unexpected_grant2");
                end else begin
                    g = grant2_q.pop_front();
                    check("grant2", 32'(req_ready2), 32'd1 << g);
                end
            end
        end
    end

    task automatic send(input int r, input logic [W-1:0] d, input int hits, input bit want_res);
        int n;
        grant_q.push_back(r);
        if (want_res) exp_q.push_back('{r, hits});
        @(posedge clk) #1;
        req_data[r*W +: W] = d;
        req_valid[r] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 100);
        if (!req_ready[r]) timeout_fail("send_grant");
        @(posedge clk) #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant_q.size() != 0 || exp2_q.size() != 0 ||
                grant2_q.size() != 0 || res_valid || res_valid2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout_fail("wait_idle");
        @(posedge clk) #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int ng;
        int seen0;

        // Reset values while rst_n is low.
        repeat (3) @(negedge clk);
        check("rst_det_rst", 32'(det_rst), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_hits", 32'(res_hits), 32'd0);
        check("rst_det_ip", 32'(det_ip), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_det_rst", 32'(det_rst), 32'd0);

        // 11010100: one hit, result in cycle A+11.
        send(0, 8'b11010100, 1, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 100);
        check("latency", 32'(lat), 32'(W + 3));
        wait_idle();

        // 11011010: no hit.
        send(0, 8'b11011010, 0, 1'b1);
        wait_idle();

        // Reset in the middle of SHIFT aborts the word.
        seen0 = res_seen;
        send(1, 8'b11010100, 1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_det_rst", 32'(det_rst), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_res_id", 32'(res_id), 32'd0);
        check("abort_res_hits", 32'(res_hits), 32'd0);
        check("abort_det_ip", 32'(det_ip), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_det_rst_hold", 32'(det_rst), 32'd1);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_result", 32'(res_seen - seen0), 32'd0);

        // All four requesters held valid: fair 0,1,2,3,0,1,2,3 order.
        for (int k = 0; k < 8; k++) begin
            grant_q.push_back(k % 4);
            case (k % 4)
                0:       exp_q.push_back('{0, 1});
                1:       exp_q.push_back('{1, 0});
                2:       exp_q.push_back('{2, 1});
                default: exp_q.push_back('{3, 0});
            endcase
        end
        @(posedge clk) #1;
        req_data  = {8'hFF, 8'h35, 8'hDA, 8'hD4};
        req_valid = 4'hF;
        ng = 0;
        n  = 0;
        while (ng < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) ng++;
        end
        if (ng < 8) timeout_fail("rr_grants");
        @(posedge clk) #1;
        req_valid = '0;
        wait_idle();

        // Result stall: outputs stable, no grants, then grants resume.
        res_ready = 1'b0;
        send(2, 8'h35, 1, 1'b1);
        grant_q.push_back(3);
        exp_q.push_back('{3, 0});
        req_data[3*W +: W] = 8'hFF;
        req_valid[3] = 1'b1;
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) timeout_fail("stall_res_valid");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_id", 32'(res_id), 32'd2);
            check("stall_res_hits", 32'(res_hits), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk) #1;
        res_ready = 1'b1;
        n = 0;
        while (!req_ready[3] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[3]) timeout_fail("stall_resume_grant");
        @(posedge clk) #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // 16-bit word D6A0: overlapping matches, two hits.
        grant2_q.push_back(1);
        exp2_q.push_back('{1, 2});
        req_data2[1*W2 +: W2] = 16'hD6A0;
        req_valid2[1] = 1'b1;
        n = 0;
        while (!req_ready2[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready2[1]) timeout_fail("w16_grant");
        @(posedge clk) #1;
        req_valid2[1] = 1'b0;
        wait_idle();

`ifdef SEQDET_TOTALS_EN
        // Accumulators: clear, three one-hit words from requester 2, clear.
        totals_clr = 1'b1;
        @(posedge clk) #1;
        totals_clr = 1'b0;
        @(negedge clk);
        check("totals_cleared", 32'(total_hits[2*TOTAL_W +: TOTAL_W]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            send(2, 8'b11010100, 1, 1'b1);
            wait_idle();
        end
        @(negedge clk);
        check("totals_req2", 32'(total_hits[2*TOTAL_W +: TOTAL_W]), 32'd3);
        check("totals_req0", 32'(total_hits[0 +: TOTAL_W]), 32'd0);
        @(posedge clk) #1;
        totals_clr = 1'b1;
        @(posedge clk) #1;
        totals_clr = 1'b0;
        @(negedge clk);
        check("totals_after_clr", 32'(total_hits[2*TOTAL_W +: TOTAL_W]), 32'd0);
`endif

        check("queues_drained", 32'(exp_q.size() + grant_q.size() + exp2_q.size() + grant2_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
